// File: rtl/gspi_pkg.sv
// gspi_pkg: shared types and constants for the gspi SPI master.
//   state_t     - controller state, 3-bit encoding (IDLE/SETUP/HIGH/LOW/DONE)
//   LANE0..2    - MISO lane indices
//   DIV_MAX     - upper limit of the SCK half-period parameter
//   lane_of()   - maps a device select onto the MISO lane to sample
package gspi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;

    localparam int DIV_MIN = 1;
    localparam int DIV_MAX = 255;

    // Device 0 wins when both selects are set; no select means the raw lane 2.
    function automatic logic [1:0] lane_of(input logic [1:0] ss);
        if (ss[0])      return LANE0;
        else if (ss[1]) return LANE1;
        else            return LANE2;
    endfunction

endpackage

// File: rtl/gspi_shifter.sv
// gspi_shifter: 8-bit bidirectional shift register shared by transmit and receive.
//   CLK, nRST  - clock, asynchronous active-low reset
//   load       - capture load_data (takes priority over shift_en)
//   load_data  - byte to transmit
//   shift_en   - shift one position, taking sin into the vacated end
//   lsb_first  - 1: shift right (bit 0 leaves first, sin enters at bit 7)
//   sin        - serial input (sampled MISO)
//   sout       - serial output, the bit currently presented on MOSI
//   q_next     - register contents after a shift, used to capture the final byte
module gspi_shifter (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift_en,
    input  logic       lsb_first,
    input  logic       sin,
    output logic       sout,
    output logic [7:0] q_next
);

    logic [7:0] sreg;

    assign q_next = lsb_first ? {sin, sreg[7:1]} : {sreg[6:0], sin};
    assign sout   = lsb_first ? sreg[0] : sreg[7];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sreg <= 8'h00;
        end else if (load) begin
            sreg <= load_data;
        end else if (shift_en) begin
            sreg <= q_next;
        end
    end

endmodule

// File: rtl/gspi_master.sv
// gspi_master: byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0).
//   CLK, nRST            - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  - command handshake (see below)
//   cmd_data, cmd_ss,
//   cmd_hold             - byte to send, device select (1 = select), keep nSS after byte
//   lsb_first            - only with GSPI_LSB_FIRST_EN defined: bit order for this byte
//   rx_data, rx_valid    - received byte and its one-cycle strobe
//   busy                 - high whenever the controller is not IDLE
//   MOSI, SCK, nSS, MISO - SPI pins; MISO has one lane per device
//   dbg_state            - current controller state
// Parameter DIV: SCK half-period in CLK cycles (1..255).
//
// Handshake: a command is accepted on a rising CLK edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE; cmd_* is ignored
// at all other times, so the requester may hold cmd_valid and the next
// command is taken on the first IDLE cycle.
module gspi_master
    import gspi_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic [1:0] cmd_ss,
    input  logic       cmd_hold,
`ifdef GSPI_LSB_FIRST_EN
    input  logic       lsb_first,
`endif
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       MOSI,
    output logic       SCK,
    output logic [1:0] nSS,
    input  logic [2:0] MISO,
    output state_t     dbg_state
);

    localparam int            PW      = $clog2(DIV + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

    state_t        state, state_nxt;
    logic [PW-1:0] ph_cnt;
    logic [2:0]    bit_cnt;
    logic [1:0]    lane;
    logic          hold_q;
    logic          lsb_q;
    logic [1:0]    nss_q;
    logic          sck_q;
    logic [7:0]    rx_q;
    logic          rxv_q;
    logic          accept;
    logic          ph_end;
    logic          shift_en;
    logic          miso_bit;
    logic          sout;
    logic [7:0]    shift_next;

    assign accept   = (state == IDLE) && cmd_valid;
    assign ph_end   = (ph_cnt == '0);
    // The sample edge is the last CLK edge of each SCK-high phase.
    assign shift_en = (state == HIGH) && ph_end;

    always_comb begin
        miso_bit = MISO[0];
        case (lane)
            LANE1:   miso_bit = MISO[1];
            LANE2:   miso_bit = MISO[2];
            default: miso_bit = MISO[0];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (ph_end) state_nxt = HIGH;
            HIGH:    if (ph_end) state_nxt = (bit_cnt == 3'd7) ? DONE : LOW;
            LOW:     if (ph_end) state_nxt = HIGH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            ph_cnt  <= '0;
            bit_cnt <= 3'd0;
            lane    <= LANE0;
            hold_q  <= 1'b0;
            nss_q   <= 2'b11;
            sck_q   <= 1'b0;
            rx_q    <= 8'h00;
            rxv_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            // SCK and rx_valid are registered from the next state so the pins
            // follow the phase boundaries without decode glitches.
            sck_q <= (state_nxt == HIGH);
            rxv_q <= (state_nxt == DONE);

            if (state_nxt != state) begin
                ph_cnt <= PH_LAST;
            end else if (!ph_end) begin
                ph_cnt <= ph_cnt - PW'(1);
            end

            if (accept) begin
                lane    <= lane_of(cmd_ss);
                hold_q  <= cmd_hold;
                nss_q   <= ~cmd_ss;
                bit_cnt <= 3'd0;
            end

            if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_q <= shift_next;
                end
            end

            if (state == DONE && !hold_q) begin
                nss_q <= 2'b11;
            end
        end
    end

`ifdef GSPI_LSB_FIRST_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lsb_q <= 1'b0;
        end else if (accept) begin
            lsb_q <= lsb_first;
        end
    end
`else
    assign lsb_q = 1'b0;
`endif

    gspi_shifter u_shifter (
        .CLK       (CLK),
        .nRST      (nRST),
        .load      (accept),
        .load_data (cmd_data),
        .shift_en  (shift_en),
        .lsb_first (lsb_q),
        .sin       (miso_bit),
        .sout      (sout),
        .q_next    (shift_next)
    );

    // MOSI idles high and only carries data while a byte is being clocked.
    assign MOSI      = (state == SETUP || state == HIGH || state == LOW) ? sout : 1'b1;
    assign SCK       = sck_q;
    assign nSS       = nss_q;
    assign rx_data   = rx_q;
    assign rx_valid  = rxv_q;
    assign busy      = (state != IDLE);
    assign cmd_ready = (state == IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_gspi_master.sv
// tb_gspi_master: directed bench for gspi_master.
// Main instance uses DIV=2; a second instance with DIV=1 covers reset mid-transfer.
// With GSPI_LSB_FIRST_EN defined an extra LSB-first byte is exercised.
module tb_gspi_master;
    import gspi_pkg::*;

    localparam int D = 2;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [1:0] cmd_ss;
    logic       cmd_hold;
    logic       lsb_first_v;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       mosi;
    logic       sck;
    logic [1:0] nss;
    logic [2:0] miso;
    state_t     dbg_state;

    logic       b_rst_n;
    logic       b_cmd_valid;
    logic       b_cmd_ready;
    logic [7:0] b_cmd_data;
    logic [1:0] b_cmd_ss;
    logic       b_cmd_hold;
    logic [7:0] b_rx_data;
    logic       b_rx_valid;
    logic       b_busy;
    logic       b_mosi;
    logic       b_sck;
    logic [1:0] b_nss;
    logic [2:0] b_miso;
    state_t     b_dbg_state;

    int n_vec;
    int n_err;

    gspi_master #(.DIV(D)) dut (
        .CLK       (clk),
        .nRST      (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_ss    (cmd_ss),
        .cmd_hold  (cmd_hold),
`ifdef GSPI_LSB_FIRST_EN
        .lsb_first (lsb_first_v),
`endif
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .MOSI      (mosi),
        .SCK       (sck),
        .nSS       (nss),
        .MISO      (miso),
        .dbg_state (dbg_state)
    );

    gspi_master #(.DIV(1)) dut_b (
        .CLK       (clk),
        .nRST      (b_rst_n),
        .cmd_valid (b_cmd_valid),
        .cmd_ready (b_cmd_ready),
        .cmd_data  (b_cmd_data),
        .cmd_ss    (b_cmd_ss),
        .cmd_hold  (b_cmd_hold),
`ifdef GSPI_LSB_FIRST_EN
        .lsb_first (1'b0),
`endif
        .rx_data   (b_rx_data),
        .rx_valid  (b_rx_valid),
        .busy      (b_busy),
        .MOSI      (b_mosi),
        .SCK       (b_sck),
        .nSS       (b_nss),
        .MISO      (b_miso),
        .dbg_state (b_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge while the DUT is IDLE; returns at the negedge of
    // cycle 16*D+2 (first IDLE cycle after the byte), so calls chain back-to-back.
    task automatic xfer(input logic [7:0] data, input logic [1:0] ss, input logic hold,
                        input logic lsb, input logic [7:0] rx);
        int         lane_i;
        int         p;
        int         idx;
        logic       b;
        logic [1:0] ss_exp;
        lane_i = ss[0] ? 0 : (ss[1] ? 1 : 2);
        ss_exp = ~ss;
        cmd_valid   = 1'b1;
        cmd_data    = data;
        cmd_ss      = ss;
        cmd_hold    = hold;
        lsb_first_v = lsb;
        check_eq("cmd_ready_before", cmd_ready, 1);
        @(posedge clk);
        #1;
        // Garbage on cmd_* while busy must be ignored.
        cmd_valid   = 1'b0;
        cmd_data    = ~data;
        cmd_ss      = ~ss;
        cmd_hold    = ~hold;
        lsb_first_v = ~lsb;
        for (int c = 1; c <= 16*D + 2; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            p   = (c - 1) / D;
            idx = p / 2;
            if (c <= 16*D) begin
                b    = lsb ? rx[idx] : rx[7-idx];
                miso = {3{~b}};
                miso[lane_i] = b;
            end
            @(negedge clk);
            if (c <= 16*D) begin
                check_eq("sck", sck, p % 2);
                check_eq("mosi", mosi, lsb ? data[idx] : data[7-idx]);
                check_eq("nss_active", nss, ss_exp);
                check_eq("rx_valid_low", rx_valid, 0);
                check_eq("cmd_ready_busy", cmd_ready, 0);
                check_eq("busy", busy, 1);
            end else if (c == 16*D + 1) begin
                check_eq("rx_valid_done", rx_valid, 1);
                check_eq("rx_data", rx_data, rx);
                check_eq("mosi_done", mosi, 1);
                check_eq("sck_done", sck, 0);
                check_eq("nss_done", nss, ss_exp);
                check_eq("state_done", dbg_state, DONE);
            end else begin
                check_eq("nss_after", nss, hold ? ss_exp : 2'b11);
                check_eq("rx_valid_after", rx_valid, 0);
                check_eq("rx_data_stable", rx_data, rx);
                check_eq("cmd_ready_after", cmd_ready, 1);
                check_eq("busy_after", busy, 0);
                check_eq("mosi_idle", mosi, 1);
            end
        end
        cmd_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        b_rst_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_data    = 8'h00;
        cmd_ss      = 2'b00;
        cmd_hold    = 1'b0;
        lsb_first_v = 1'b0;
        miso        = 3'b000;
        b_cmd_valid = 1'b0;
        b_cmd_data  = 8'h00;
        b_cmd_ss    = 2'b00;
        b_cmd_hold  = 1'b0;
        b_miso      = 3'b000;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        b_rst_n = 1'b1;

        // Reset values, then idle with no activity.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("rst_sck", sck, 0);
            check_eq("rst_mosi", mosi, 1);
            check_eq("rst_nss", nss, 2'b11);
            check_eq("rst_cmd_ready", cmd_ready, 1);
            check_eq("rst_rx_valid", rx_valid, 0);
        end
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_state", dbg_state, IDLE);

        // Single byte, device 0.
        xfer(8'hA5, 2'b01, 1'b0, 1'b0, 8'h3C);
        // Two-byte transaction held on device 1.
        xfer(8'h9F, 2'b10, 1'b1, 1'b0, 8'h5A);
        xfer(8'h00, 2'b10, 1'b0, 1'b0, 8'hC3);
        // No select: lane 2 is sampled, others driven to the opposite value.
        xfer(8'h66, 2'b00, 1'b0, 1'b0, 8'hFF);
        // Both selects -> lane 0; then select replaced while nSS held.
        xfer(8'h81, 2'b11, 1'b1, 1'b0, 8'h96);
        xfer(8'h7E, 2'b01, 1'b0, 1'b0, 8'h24);
`ifdef GSPI_LSB_FIRST_EN
        xfer(8'h01, 2'b01, 1'b0, 1'b1, 8'hB4);
        xfer(8'hC8, 2'b10, 1'b0, 1'b0, 8'h1D);
`endif

        // Reset in cycle 10 of a DIV=1 transfer on the second instance.
        @(negedge clk);
        b_cmd_valid = 1'b1;
        b_cmd_data  = 8'hC3;
        b_cmd_ss    = 2'b10;
        b_cmd_hold  = 1'b1;
        @(posedge clk);
        #1;
        b_cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("b_nss_cycle9", b_nss, 2'b01);
        check_eq("b_sck_cycle9", b_sck, 0);
        @(posedge clk);
        #1;
        check_eq("b_sck_cycle10", b_sck, 1);
        b_rst_n = 1'b0;
        #1;
        check_eq("b_rst_nss", b_nss, 2'b11);
        check_eq("b_rst_sck", b_sck, 0);
        check_eq("b_rst_mosi", b_mosi, 1);
        check_eq("b_rst_busy", b_busy, 0);
        repeat (2) @(negedge clk);
        b_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("b_post_rx_valid", b_rx_valid, 0);
            check_eq("b_post_cmd_ready", b_cmd_ready, 1);
            check_eq("b_post_nss", b_nss, 2'b11);
        end
        check_eq("b_post_rx_data", b_rx_data, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
